// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the iterative multiply/divide unit.
//   op_e    : operation encoding carried on OP
//   state_e : control states IDLE / CALC / FIN
//   DIV0_QUOT : all-ones pattern returned as the quotient of a divide by zero
//               (truncated to the datapath width at the point of use)
package muldiv_pkg;

    localparam int unsigned MAX_W = 64;

    // Quotient delivered for DIVU with a zero divisor.
    localparam logic [MAX_W-1:0] DIV0_QUOT = '1;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MULHU = 2'b01,
        OP_DIVU  = 2'b10,
        OP_REMU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIN  = 2'b10
    } state_e;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the multiply/divide datapath.
// Build option: MULDIV_EARLY_EXIT_EN ends a multiply once the remaining
// multiplier is zero.
//   op_i     : operation (op_e encoding)
//   acc_i    : product (multiply) or partial remainder in [W:0] (divide)
//   a_i      : multiplicand (multiply) or dividend/quotient shift reg (divide)
//   b_i      : right-shifting multiplier (multiply) or divisor (divide)
//   cnt_i    : iteration index 0..W-1
//   acc_c_o, a_c_o, b_c_o : next register values
//   res_c_o  : result selected from the next values (valid on the last step)
//   last_c_o : this iteration is the final one
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned W  = 8,
    parameter int unsigned CW = 3
) (
    input  logic [1:0]     op_i,
    input  logic [2*W-1:0] acc_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    input  logic [CW-1:0]  cnt_i,
    output logic [2*W-1:0] acc_c_o,
    output logic [W-1:0]   a_c_o,
    output logic [W-1:0]   b_c_o,
    output logic [W-1:0]   res_c_o,
    output logic           last_c_o
);

    logic [W:0]     rem_sh;
    logic [W+1:0]   diff;
    logic [2*W-1:0] addend;

    // Restoring divide: bring in the next dividend bit, trial-subtract divisor.
    // The remainder is always below the divisor, so acc_i[W] is never needed.
    assign rem_sh = {acc_i[W-1:0], a_i[W-1]};
    assign diff   = {1'b0, rem_sh} - {2'b00, b_i};

    // Shift-add multiply: multiplicand weighted by the current bit position.
    assign addend = {{W{1'b0}}, a_i} << cnt_i;

    always_comb begin
        acc_c_o  = acc_i;
        a_c_o    = a_i;
        b_c_o    = b_i;
        res_c_o  = '0;
        last_c_o = (cnt_i == CW'(W - 1));

        if (op_i[1]) begin
            // Borrow out means the trial subtraction went negative: restore.
            if (diff[W+1]) begin
                acc_c_o = {{(W-1){1'b0}}, rem_sh};
                a_c_o   = {a_i[W-2:0], 1'b0};
            end else begin
                acc_c_o = {{(W-1){1'b0}}, diff[W:0]};
                a_c_o   = {a_i[W-2:0], 1'b1};
            end
        end else begin
            if (b_i[0]) begin
                acc_c_o = acc_i + addend;
            end
            b_c_o = b_i >> 1;
`ifdef MULDIV_EARLY_EXIT_EN
            if (b_c_o == '0) begin
                last_c_o = 1'b1;
            end
`endif
        end

        case (op_e'(op_i))
            OP_MUL:   res_c_o = acc_c_o[W-1:0];
            OP_MULHU: res_c_o = acc_c_o[2*W-1:W];
            OP_DIVU:  res_c_o = a_c_o;
            OP_REMU:  res_c_o = acc_c_o[W-1:0];
            default:  res_c_o = '0;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative unsigned multiply/divide unit feeding register-file
// write-back. One iteration per clock, W iterations per operation.
// Build option: MULDIV_EARLY_EXIT_EN (shortened multiply, see muldiv_step).
//   CLK, RESET : clock, synchronous active-high reset
//   START      : request; only sampled in IDLE
//   OP         : 00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   DATA1/DATA2: operands (multiplicand/dividend, multiplier/divisor)
//   DEST       : destination register address
//   BUSY       : high whenever not IDLE (stall request)
//   DONE       : one-cycle write-back strobe
//   RESULT     : result, held until the next completion
//   WRADDR     : destination address for write-back
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned W = 8,
    parameter int unsigned A = 3
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         START,
    input  logic [1:0]   OP,
    input  logic [W-1:0] DATA1,
    input  logic [W-1:0] DATA2,
    input  logic [A-1:0] DEST,
    output logic         BUSY,
    output logic         DONE,
    output logic [W-1:0] RESULT,
    output logic [A-1:0] WRADDR
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    state_e         state_q;
    logic [1:0]     op_q;
    logic [2*W-1:0] acc_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [CW-1:0]  cnt_q;
    logic [A-1:0]   dest_q;
    logic           busy_q;
    logic           done_q;
    logic [W-1:0]   result_q;
    logic [A-1:0]   wraddr_q;

    logic [2*W-1:0] acc_d;
    logic [W-1:0]   a_d;
    logic [W-1:0]   b_d;
    logic [W-1:0]   res_d;
    logic           last_d;

    muldiv_step #(
        .W  (W),
        .CW (CW)
    ) u_step (
        .op_i     (op_q),
        .acc_i    (acc_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .cnt_i    (cnt_q),
        .acc_c_o  (acc_d),
        .a_c_o    (a_d),
        .b_c_o    (b_d),
        .res_c_o  (res_d),
        .last_c_o (last_d)
    );

    // Control FSM and datapath registers; DONE/RESULT/WRADDR change together.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            acc_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            dest_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            wraddr_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        op_q   <= OP;
                        dest_q <= DEST;
                        a_q    <= DATA1;
                        b_q    <= DATA2;
                        acc_q  <= '0;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        if (OP[1] && (DATA2 == '0)) begin
                            // Divide by zero bypasses iteration entirely.
                            state_q  <= S_FIN;
                            done_q   <= 1'b1;
                            wraddr_q <= DEST;
                            result_q <= (op_e'(OP) == OP_DIVU) ? W'(DIV0_QUOT) : DATA1;
`ifdef MULDIV_EARLY_EXIT_EN
                        end else if (!OP[1] && (DATA2 == '0)) begin
                            state_q  <= S_FIN;
                            done_q   <= 1'b1;
                            wraddr_q <= DEST;
                            result_q <= '0;
`endif
                        end else begin
                            state_q <= S_CALC;
                        end
                    end
                end

                S_CALC: begin
                    acc_q <= acc_d;
                    a_q   <= a_d;
                    b_q   <= b_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_d) begin
                        state_q  <= S_FIN;
                        done_q   <= 1'b1;
                        result_q <= res_d;
                        wraddr_q <= dest_q;
                    end
                end

                S_FIN: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    cnt_q   <= '0;
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign RESULT = result_q;
    assign WRADDR = wraddr_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 8-bit multiply/divide execution unit sitting directly downstream of the register file. It consumes the two register read ports (OUT1/OUT2) as operands and returns one result plus destination address for write-back into the register file's IN/INADDRESS/WRITE port. While an operation is in flight it asserts BUSY so the control unit stalls PC and instruction fetch.

## Interface

Parameters:
- W, 8, operand/result width (register width)
- A, 3, register address width

Ports:
- CLK  input  1  clock; all state changes on posedge
- RESET  input  1  reset, synchronous, active-high
- START  input  1  request a new operation; sampled only in IDLE
- OP  input  2  00 MUL (low W bits), 01 MULHU (high W bits, unsigned), 10 DIVU, 11 REMU
- DATA1  input  W  operand 1 (multiplicand / dividend), from register file OUT1
- DATA2  input  W  operand 2 (multiplier / divisor), from register file OUT2
- DEST  input  A  destination register address
- BUSY  output  1  high whenever state is not IDLE
- DONE  output  1  one-cycle pulse: result valid, write-back request
- RESULT  output  W  operation result; held from DONE until the next accepted START
- WRADDR  output  A  latched DEST; drives register-file INADDRESS

## Operation

- States: IDLE, CALC, FIN.
- IDLE: START=1 at posedge latches OP, DATA1, DATA2 and DEST, clears the accumulator and iteration counter, and moves to CALC.
  - Exception: DIVU/REMU with DATA2=0 goes straight to FIN. RESULT is 0xFF (all ones) for DIVU and DATA1 for REMU.
- CALC: one iteration per clock, counter 0..W-1; after iteration W-1, go to FIN.
  - Multiply: shift-add over a 2W-bit product. If multiplier bit i is set, add DATA1<<i; unsigned. MUL takes product[W-1:0]; MULHU takes product[2W-1:W].
  - Divide: restoring division, W+1-bit partial remainder, one quotient bit per cycle MSB first. DIVU returns the quotient, REMU the remainder.
- FIN: DONE=1 for exactly one cycle, RESULT/WRADDR updated; go to IDLE unconditionally.
- START while BUSY (CALC or FIN) is ignored, not queued; operand inputs may change freely after acceptance.
- DONE drives register-file WRITE directly; WRADDR drives INADDRESS.

## Timing

- Reset (RESET=1 at posedge, any state including mid-CALC): state IDLE, BUSY=0, DONE=0, RESULT=0, WRADDR=0, counter=0. No DONE pulse is emitted for the aborted operation.
- Latency, measured from the accepting edge E0:
  - Normal: DONE is high in the cycle after edge E0+W, i.e. W+1 cycles of BUSY (W=8: 8 CALC + 1 FIN).
  - Divide by zero: DONE is high in the cycle after E0 (1 BUSY cycle).
- Earliest next acceptance is the edge that ends the FIN cycle +1, i.e. the first IDLE cycle.
- Outputs are registered; no combinational path from START to BUSY or DONE.

## Configuration

- Macro MULDIV_EARLY_EXIT_EN.
  - Defined: for MUL/MULHU, CALC exits to FIN on the edge where the remaining (right-shifted) multiplier becomes zero. DATA2=0 goes straight from IDLE to FIN with RESULT=0. Multiply latency is therefore (index of highest set bit of DATA2)+1 CALC cycles plus FIN. Divide is unaffected.
  - Undefined: every non-div-by-zero operation takes exactly W CALC cycles, and MUL by 0 takes the full W cycles with RESULT=0.

## Structure

- Package muldiv_pkg holds:
  - op enum (OP_MUL, OP_MULHU, OP_DIVU, OP_REMU)
  - state enum (S_IDLE, S_CALC, S_FIN)
  - the div-by-zero quotient constant (all ones)
- One sub-module, muldiv_step: combinational single iteration, taking {op, accumulator, operand regs, counter} and producing the next values. The top level holds the FSM, counter and registers.

## Test plan

- MUL 13×11 (0x0D×0x0B), DEST=5, macro undefined → DONE after 9 BUSY cycles, RESULT=0x8F, WRADDR=5, exactly one DONE cycle.
- MULHU 200×200 → RESULT=0x9C (40000=0x9C40); MUL with same operands → RESULT=0x40.
- DIVU 200/7 → RESULT=0x1C; REMU 200/7 → RESULT=0x04; each 9 BUSY cycles.
- DIVU 0x2A/0 → RESULT=0xFF; REMU 0x2A/0 → RESULT=0x2A; DONE in cycle after acceptance.
- START pulsed during CALC with different operands → ignored, original result delivered; RESET asserted at CALC cycle 4 → BUSY=0, RESULT=0, no DONE next cycles.
- MULDIV_EARLY_EXIT_EN defined: MUL 100×3 → RESULT=0x2C after 2 CALC + 1 FIN cycles; MUL 7×0 → RESULT=0, DONE cycle after acceptance; same vectors without macro → 9 BUSY cycles.
